// File: rtl/sram_2p_march_bist.sv
// ---------------------------------------------------------------------------
// sram_2p_march_bist
//
// March C- BIST engine for the A_BIST_* port group of a dual-port SRAM
// macro. It issues one write or read request per cycle, compares the data
// returned on DOUT after P_READ_LAT edges, and reports pass/fail along with
// diagnostics for the first failure.
//
// March C- elements (D0 = all zeros, D1 = all ones):
//   E0 up(w D0)  E1 up(r D0, w D1)  E2 up(r D1, w D0)
//   E3 down(r D0, w D1)  E4 down(r D1, w D0)  E5 up(r D0)
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   START             run request, honoured only in IDLE or DONE
//   DOUT              macro read data (A_DOUT)
//   BIST_EN/MEN/WEN/REN/ADDR/DIN/BM   registered requests to the macro
//   BUSY, DONE        status (BUSY in RUN and DRAIN; DONE held until START)
//   FAIL, FAIL_ADDR, FAIL_ELEM, FAIL_CNT   sticky result and diagnostics
//   STATE_DBG         current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: there is no back-pressure. Every cycle with MEN=1 is one
// accepted request; a read launched at edge L is sampled from DOUT at edge
// L+P_READ_LAT.
// ---------------------------------------------------------------------------
module sram_2p_march_bist #(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_READ_LAT   = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    START,
  input  logic [P_DATA_WIDTH-1:0] DOUT,
  output logic                    BIST_EN,
  output logic                    BIST_MEN,
  output logic                    BIST_WEN,
  output logic                    BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] BIST_BM,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [2:0]              FAIL_ELEM,
  output logic [7:0]              FAIL_CNT,
  output logic [1:0]              STATE_DBG
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int LAST = P_READ_LAT - 1;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = P_ADDR_WIDTH'(1);

  state_e state_q, state_d;

  // March position: element, address, and slot within an r/w element
  // (phase 0 = read slot, phase 1 = write slot).
  logic [2:0]              elem_q, elem_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    phase_q, phase_d;

  // Registered request outputs.
  logic                    men_q, men_d;
  logic                    wen_q, wen_d;
  logic                    ren_q, ren_d;
  logic [P_ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [P_DATA_WIDTH-1:0] din_q, din_d;
  logic [P_DATA_WIDTH-1:0] bm_q, bm_d;

  // Result registers.
  logic                    fail_q, fail_d;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]              fail_elem_q, fail_elem_d;
  logic [7:0]              fail_cnt_q, fail_cnt_d;

  // Compare pipeline: stage 0 is loaded at the launch edge, stage LAST is
  // compared against DOUT on the following edge.
  logic                    pv_q    [P_READ_LAT];
  logic                    pexp_q  [P_READ_LAT];
  logic [P_ADDR_WIDTH-1:0] paddr_q [P_READ_LAT];
  logic [2:0]              pelem_q [P_READ_LAT];

  logic launch;
  logic start_acc;
  logic op_is_read;
  logic op_bg;
  logic single_op;
  logic dir_down;
  logic addr_end;
  logic push_valid;
  logic push_exp;
  logic pipe_empty;
  logic mismatch;

  always_comb begin
    pipe_empty = 1'b1;
    for (int i = 0; i < P_READ_LAT; i++) begin
      if (pv_q[i]) pipe_empty = 1'b0;
    end
  end

  always_comb begin
    // Decode of the current march position.
    dir_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
    single_op  = (elem_q == 3'd0) || (elem_q == 3'd5);
    op_is_read = (elem_q == 3'd5) || ((elem_q != 3'd0) && !phase_q);
    // Background bit: reads expect D1 in E2/E4, writes store D1 in E1/E3.
    if (op_is_read) op_bg = (elem_q == 3'd2) || (elem_q == 3'd4);
    else            op_bg = (elem_q == 3'd1) || (elem_q == 3'd3);
    addr_end   = dir_down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    start_acc  = START && ((state_q == S_IDLE) || (state_q == S_DONE));
    launch     = (state_q == S_RUN);
  end

  // Next-state and request generation.
  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    addr_d     = addr_q;
    phase_d    = phase_q;
    men_d      = 1'b0;
    wen_d      = 1'b0;
    ren_d      = 1'b0;
    req_addr_d = '0;
    din_d      = '0;
    push_valid = 1'b0;
    push_exp   = 1'b0;

    case (state_q)
      S_IDLE:  if (START) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      S_DRAIN: if (pipe_empty) state_d = S_DONE;
      S_DONE:  if (START) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      men_d      = 1'b1;
      ren_d      = op_is_read;
      wen_d      = !op_is_read;
      req_addr_d = addr_q;
      din_d      = (!op_is_read && op_bg) ? '1 : '0;
      push_valid = op_is_read;
      push_exp   = op_bg;
      if (single_op || phase_q) begin
        phase_d = 1'b0;
        if (addr_end) begin
          // Element boundary: advance and reload the start address for the
          // next element's direction in the same cycle.
          if (elem_q == 3'd5) begin
            state_d = S_DRAIN;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
          end
        end else begin
          addr_d = dir_down ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        end
      end else begin
        phase_d = 1'b1;
      end
    end

    // Counters sit at the start of E0 whenever no run is in progress.
    if (state_q != S_RUN) begin
      elem_d  = 3'd0;
      addr_d  = '0;
      phase_d = 1'b0;
    end

    bm_d = (launch || (state_d == S_RUN)) ? '1 : '0;
  end

  // Result update: START clears, otherwise accumulate miscompares.
  always_comb begin
    mismatch    = pv_q[LAST] && (DOUT != {P_DATA_WIDTH{pexp_q[LAST]}});
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_cnt_d  = fail_cnt_q;
    if (start_acc) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = 3'd0;
      fail_cnt_d  = 8'd0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
      if (!fail_q) begin
        fail_addr_d = paddr_q[LAST];
        fail_elem_d = pelem_q[LAST];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      elem_q      <= 3'd0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      men_q       <= 1'b0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      req_addr_q  <= '0;
      din_q       <= '0;
      bm_q        <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      fail_cnt_q  <= 8'd0;
      for (int i = 0; i < P_READ_LAT; i++) begin
        pv_q[i]    <= 1'b0;
        pexp_q[i]  <= 1'b0;
        paddr_q[i] <= '0;
        pelem_q[i] <= 3'd0;
      end
    end else begin
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      men_q       <= men_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      req_addr_q  <= req_addr_d;
      din_q       <= din_d;
      bm_q        <= bm_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_cnt_q  <= fail_cnt_d;
      pv_q[0]     <= push_valid;
      pexp_q[0]   <= push_exp;
      paddr_q[0]  <= addr_q;
      pelem_q[0]  <= elem_q;
      for (int i = 1; i < P_READ_LAT; i++) begin
        pv_q[i]    <= pv_q[i-1];
        pexp_q[i]  <= pexp_q[i-1];
        paddr_q[i] <= paddr_q[i-1];
        pelem_q[i] <= pelem_q[i-1];
      end
    end
  end

  assign BIST_EN   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign BUSY      = BIST_EN;
  assign DONE      = (state_q == S_DONE);
  assign BIST_MEN  = men_q;
  assign BIST_WEN  = wen_q;
  assign BIST_REN  = ren_q;
  assign BIST_ADDR = req_addr_q;
  assign BIST_DIN  = din_q;
  assign BIST_BM   = bm_q;
  assign FAIL      = fail_q;
  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_ELEM = fail_elem_q;
  assign FAIL_CNT  = fail_cnt_q;
  assign STATE_DBG = state_q;

endmodule
